// File: rtl/ll_pkg.sv
// Shared definitions for the packet-mode link-layer FIFO: memory word layout and write FSM states.
package ll_pkg;
  // Memory word is {data, err, eof, sof}
  localparam int SOF_BIT  = 0;
  localparam int EOF_BIT  = 1;
  localparam int ERR_BIT  = 2;
  localparam int DATA_LSB = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } wr_state_e;
endpackage

// File: rtl/ll_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read that holds when re is low.
module ll_fifo_ram #(
  parameter int DW = 11,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ll_pkt_fifo.sv
// Packet-mode FIFO: frames become visible downstream only after EOF commits; errored,
// overrun and malformed frames are dropped by rolling the speculative write pointer back.
module ll_pkt_fifo
  import ll_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int AWIDTH   = 6,
  parameter int DROP_ERR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  datain,
  input  logic              sof_i,
  input  logic              eof_i,
  input  logic              error_i,
  input  logic              src_rdy_i,
  output logic              dst_rdy_o,
  output logic [WIDTH-1:0]  dataout,
  output logic              sof_o,
  output logic              eof_o,
  output logic              error_o,
  output logic              src_rdy_o,
  input  logic              dst_rdy_i,
  output logic [AWIDTH:0]   occupied,
  output logic [AWIDTH:0]   pkt_count,
  output logic              overrun,
  output logic [15:0]       drop_count
);
  localparam int MW = WIDTH + 3;
  localparam logic [AWIDTH:0] DEPTH_P = {1'b1, {AWIDTH{1'b0}}};

  wr_state_e        state, nstate;
  logic [AWIDTH:0]  wr_ptr, commit_ptr, rd_ptr, out_ptr;
  logic [AWIDTH:0]  nwr, ncommit, wr_used, new_used;
  logic             err_lat, nerr, rdy_en, drop, ovf, bad, full, full_new, in_xfer;
  logic             we, re, ram_vld, out_vld, move, out_xfer, commit_inc, pkt_dec;
  logic [AWIDTH-1:0] waddr;
  logic [MW-1:0]    wdata, rdata, out_word;

  assign dst_rdy_o = rdy_en;
  assign in_xfer   = src_rdy_i & dst_rdy_o;
  assign wr_used   = wr_ptr - rd_ptr;
  assign new_used  = commit_ptr - rd_ptr;
  assign full      = (wr_used == DEPTH_P);
  assign full_new  = (new_used == DEPTH_P);
  assign bad       = (DROP_ERR != 0) && error_i;

  // Outside PKT wr_ptr == commit_ptr, so every new frame starts at commit_ptr.
  always_comb begin
    nstate  = state;
    nwr     = wr_ptr;
    ncommit = commit_ptr;
    nerr    = err_lat;
    drop    = 1'b0;
    ovf     = 1'b0;
    we      = 1'b0;
    waddr   = wr_ptr[AWIDTH-1:0];
    wdata   = '0;
    wdata[DATA_LSB +: WIDTH] = datain;
    wdata[SOF_BIT] = sof_i;
    wdata[EOF_BIT] = eof_i;
    if (in_xfer) begin
      if (sof_i) begin
        drop   = (state == PKT);
        nwr    = commit_ptr;
        nstate = eof_i ? IDLE : DROP;
        if (full_new) begin
          ovf  = 1'b1;
          drop = 1'b1;
        end else if (bad) begin
          drop = 1'b1;
        end else begin
          we             = 1'b1;
          waddr          = commit_ptr[AWIDTH-1:0];
          nerr           = error_i;
          wdata[ERR_BIT] = eof_i & error_i;
          nwr            = commit_ptr + 1'b1;
          if (eof_i) ncommit = commit_ptr + 1'b1;
          else       nstate  = PKT;
        end
      end else begin
        case (state)
          IDLE: drop = 1'b1;
          PKT: begin
            if (full || bad) begin
              ovf    = full;
              drop   = 1'b1;
              nwr    = commit_ptr;
              nstate = eof_i ? IDLE : DROP;
            end else begin
              we             = 1'b1;
              nerr           = err_lat | error_i;
              wdata[ERR_BIT] = eof_i & (err_lat | error_i);
              nwr            = wr_ptr + 1'b1;
              if (eof_i) begin
                ncommit = wr_ptr + 1'b1;
                nstate  = IDLE;
              end
            end
          end
          default: if (eof_i) nstate = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE; wr_ptr <= '0; commit_ptr <= '0;
      err_lat <= 1'b0; overrun <= 1'b0; rdy_en <= 1'b0;
    end else if (clear) begin
      state <= IDLE; wr_ptr <= '0; commit_ptr <= '0;
      err_lat <= 1'b0; overrun <= 1'b0; rdy_en <= 1'b0;
    end else begin
      state      <= nstate;
      wr_ptr     <= nwr;
      commit_ptr <= ncommit;
      err_lat    <= nerr;
      overrun    <= ovf;
      rdy_en     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_count <= '0;
    else if (!clear && drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end

  ll_fifo_ram #(.DW(MW), .AW(AWIDTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_ptr[AWIDTH-1:0]),
    .rdata (rdata)
  );

  // Two-stage read: RAM output register feeds a one-word output register.
  assign out_xfer   = out_vld & dst_rdy_i;
  assign move       = ram_vld & (~out_vld | out_xfer);
  assign re         = (rd_ptr != commit_ptr) & (~ram_vld | move);
  assign commit_inc = (ncommit != commit_ptr);
  assign pkt_dec    = out_xfer & out_word[EOF_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0; out_ptr <= '0; ram_vld <= 1'b0; out_vld <= 1'b0;
      out_word <= '0; pkt_count <= '0;
    end else if (clear) begin
      rd_ptr <= '0; out_ptr <= '0; ram_vld <= 1'b0; out_vld <= 1'b0;
      out_word <= '0; pkt_count <= '0;
    end else begin
      if (re)       rd_ptr  <= rd_ptr + 1'b1;
      if (out_xfer) out_ptr <= out_ptr + 1'b1;
      ram_vld <= re | (ram_vld & ~move);
      if (move) begin
        out_vld  <= 1'b1;
        out_word <= rdata;
      end else if (out_xfer) begin
        out_vld <= 1'b0;
      end
      if (commit_inc && !pkt_dec)      pkt_count <= pkt_count + 1'b1;
      else if (!commit_inc && pkt_dec) pkt_count <= pkt_count - 1'b1;
    end
  end

  assign src_rdy_o = out_vld;
  assign dataout   = out_word[DATA_LSB +: WIDTH];
  assign sof_o     = out_word[SOF_BIT];
  assign eof_o     = out_word[EOF_BIT];
  assign error_o   = out_word[ERR_BIT];
  assign occupied  = commit_ptr - out_ptr;
endmodule

// File: tb/tb_ll_pkt_fifo.sv
// Bench for ll_pkt_fifo: a 64-deep drop-on-error instance and a 16-deep keep-error instance
// share one input stream; their output streams are compared against hand-computed frames.
module tb_ll_pkt_fifo;
  logic       clk, rst_n, clear;
  logic [7:0] datain;
  logic       sof_i, eof_i, error_i, src_rdy_i, dst_rdy_i;

  logic       rdy1, s1, sof1, eof1, err1, ovf1;
  logic [7:0] d1;
  logic [6:0] occ1, pc1;
  logic [15:0] dc1;
  logic       rdy0, s0, sof0, eof0, err0, ovf0;
  logic [7:0] d0;
  logic [4:0] occ0, pc0;
  logic [15:0] dc0;

  ll_pkt_fifo #(.WIDTH(8), .AWIDTH(6), .DROP_ERR(1)) u1 (
    .clk(clk), .reset(rst_n), .clear(clear), .datain(datain), .sof_i(sof_i), .eof_i(eof_i),
    .error_i(error_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(rdy1), .dataout(d1), .sof_o(sof1),
    .eof_o(eof1), .error_o(err1), .src_rdy_o(s1), .dst_rdy_i(dst_rdy_i), .occupied(occ1),
    .pkt_count(pc1), .overrun(ovf1), .drop_count(dc1));

  ll_pkt_fifo #(.WIDTH(8), .AWIDTH(4), .DROP_ERR(0)) u0 (
    .clk(clk), .reset(rst_n), .clear(clear), .datain(datain), .sof_i(sof_i), .eof_i(eof_i),
    .error_i(error_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(rdy0), .dataout(d0), .sof_o(sof0),
    .eof_o(eof0), .error_o(err0), .src_rdy_o(s0), .dst_rdy_i(dst_rdy_i), .occupied(occ0),
    .pkt_count(pc0), .overrun(ovf0), .drop_count(dc0));

  typedef logic [10:0] word_t;   // {data, err, eof, sof}
  word_t q1[$], q0[$];

  typedef struct {
    int len; int err_at;
    int n1; int d1; int n0; int d0; bit el0;
  } vec_t;
  vec_t tbl[7];

  int n_cmp = 0, n_bad = 0;
  int exp_drop1 = 0, exp_drop0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (s1 && dst_rdy_i) q1.push_back({d1, err1, eof1, sof1});
      if (s0 && dst_rdy_i) q0.push_back({d0, err0, eof0, sof0});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    clear = 1'b1; tick();
    clear = 1'b0; tick();
    q1.delete(); q0.delete();
  endtask

  task automatic send(input int len, input int seed, input int err_at, input bit eof_last);
    for (int i = 0; i < len; i++) begin
      src_rdy_i = 1'b1; datain = 8'(seed + i);
      sof_i = (i == 0); eof_i = eof_last && (i == len - 1); error_i = (i == err_at);
      tick();
    end
    src_rdy_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; error_i = 1'b0;
  endtask

  task automatic check_frame(input string nm, input bit which, input int n, input int seed, input bit el);
    int sz, nbad;
    word_t w, e;
    sz = which ? q1.size() : q0.size();
    chk({nm, " count"}, sz, n);
    nbad = 0;
    for (int i = 0; i < n && i < sz; i++) begin
      w = which ? q1[i] : q0[i];
      e = {8'(seed + i), (el && (i == n - 1)), (i == n - 1), (i == 0)};
      if (w !== e) nbad++;
    end
    if (n > 0) chk({nm, " words"}, nbad, 0);
  endtask

  initial begin
    tbl[0] = '{len:60, err_at:-1, n1:60, d1:0, n0:0,  d0:1, el0:0};
    tbl[1] = '{len:10, err_at:9,  n1:0,  d1:1, n0:10, d0:0, el0:1};
    tbl[2] = '{len:6,  err_at:-1, n1:6,  d1:0, n0:6,  d0:0, el0:0};
    tbl[3] = '{len:1,  err_at:-1, n1:1,  d1:0, n0:1,  d0:0, el0:0};
    tbl[4] = '{len:16, err_at:-1, n1:16, d1:0, n0:16, d0:0, el0:0};
    tbl[5] = '{len:17, err_at:-1, n1:17, d1:0, n0:0,  d0:1, el0:0};
    tbl[6] = '{len:5,  err_at:2,  n1:0,  d1:1, n0:5,  d0:0, el0:1};

    rst_n = 1'b0; clear = 1'b0; datain = '0; sof_i = 0; eof_i = 0; error_i = 0;
    src_rdy_i = 0; dst_rdy_i = 0;
    tick(); tick();
    chk("rst src_rdy_o", s1, 0);
    chk("rst dst_rdy_o", rdy1, 0);
    chk("rst occupied", occ1, 0);
    chk("rst pkt_count", pc1, 0);
    chk("rst drop_count", dc1, 0);
    chk("rst dataout", {d1, sof1, eof1, err1, ovf1}, 0);
    rst_n = 1'b1;
    chk("rst release dst_rdy_o", rdy1, 0);
    tick();
    chk("first clk dst_rdy_o", rdy1, 1);

    // 60-byte frame: first word two clocks after EOF commit
    dst_rdy_i = 1'b1;
    clr();
    send(60, 5, -1, 1);
    chk("lat pkt_count", pc1, 1);
    chk("lat occupied", occ1, 60);
    tick();
    chk("lat src_rdy E1", s1, 0);
    tick();
    chk("lat src_rdy E2", s1, 1);
    chk("lat sof E2", sof1, 1);
    chk("lat data E2", d1, 5);
    repeat (70) tick();
    check_frame("lat frame", 1, 60, 5, 0);
    chk("lat pkt_count drained", pc1, 0);
    exp_drop0++;

    for (int r = 0; r < 7; r++) begin
      clr();
      send(tbl[r].len, 16 * r + 3, tbl[r].err_at, 1);
      repeat (70) tick();
      check_frame($sformatf("row%0d u1", r), 1, tbl[r].n1, 16 * r + 3, 0);
      check_frame($sformatf("row%0d u0", r), 0, tbl[r].n0, 16 * r + 3, tbl[r].el0);
      exp_drop1 += tbl[r].d1;
      exp_drop0 += tbl[r].d0;
      chk($sformatf("row%0d drop1", r), dc1, exp_drop1);
      chk($sformatf("row%0d drop0", r), dc0, exp_drop0);
      chk($sformatf("row%0d occ1", r), occ1, 0);
      chk($sformatf("row%0d pc1", r), pc1, 0);
    end

    // word without SOF in IDLE
    clr();
    src_rdy_i = 1'b1; datain = 8'hAA; eof_i = 1'b1;
    tick();
    src_rdy_i = 1'b0; eof_i = 1'b0;
    repeat (5) tick();
    exp_drop1++; exp_drop0++;
    chk("nosof out", q1.size(), 0);
    chk("nosof drop1", dc1, exp_drop1);
    chk("nosof drop0", dc0, exp_drop0);

    // SOF in the middle of an unfinished frame
    clr();
    send(5, 8'h20, -1, 0);
    send(6, 8'h40, -1, 1);
    repeat (15) tick();
    exp_drop1++; exp_drop0++;
    check_frame("miss eof u1", 1, 6, 8'h40, 0);
    check_frame("miss eof u0", 0, 6, 8'h40, 0);
    chk("miss eof drop1", dc1, exp_drop1);

    // overflow on the 16-deep instance with the consumer stalled
    begin
      int ovp, ova, lowr;
      dst_rdy_i = 1'b0;
      clr();
      ovp = 0; ova = 0; lowr = 0;
      for (int i = 0; i < 20; i++) begin
        src_rdy_i = 1'b1; datain = 8'(8'h50 + i);
        sof_i = (i == 0); eof_i = (i == 19);
        if (!rdy0) lowr++;
        tick();
        if (ovf0) begin ovp++; ova = i + 1; end
      end
      src_rdy_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
      tick();
      exp_drop0++;
      chk("ovf pulses", ovp, 1);
      chk("ovf word", ova, 17);
      chk("ovf dst_rdy low", lowr, 0);
      chk("ovf occupied", occ0, 0);
      send(5, 8'h90, -1, 1);
      tick(); tick();
      chk("ovf next occupied", occ0, 5);
      chk("ovf next pkt_count", pc0, 1);
      chk("ovf next src_rdy", s0, 1);
      dst_rdy_i = 1'b1;
      repeat (40) tick();
      check_frame("ovf next", 0, 5, 8'h90, 0);
      chk("ovf drop0", dc0, exp_drop0);
    end

    // clear flushes committed data but keeps drop_count
    dst_rdy_i = 1'b0;
    clr();
    send(3, 8'hB0, -1, 1);
    repeat (3) tick();
    chk("clr pre pkt_count", pc1, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr occupied", occ1, 0);
    chk("clr pkt_count", pc1, 0);
    chk("clr src_rdy", s1, 0);
    chk("clr drop kept", dc1, exp_drop1);
    tick();

    // asynchronous reset in the middle of a frame with two frames committed
    send(3, 8'h60, -1, 1);
    send(3, 8'h70, -1, 1);
    repeat (3) tick();
    chk("rstmid pre pkt_count", pc1, 2);
    chk("rstmid pre src_rdy", s1, 1);
    src_rdy_i = 1'b1; sof_i = 1'b1; datain = 8'hC0;
    tick();
    sof_i = 1'b0; datain = 8'hC1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid src_rdy", s1, 0);
    chk("rstmid occupied", occ1, 0);
    chk("rstmid pkt_count", pc1, 0);
    chk("rstmid dst_rdy", rdy1, 0);
    chk("rstmid drop", dc1, 0);
    src_rdy_i = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid release dst_rdy", rdy1, 0);
    tick();
    chk("rstmid first clk dst_rdy", rdy1, 1);
    dst_rdy_i = 1'b1;
    q1.delete(); q0.delete();
    send(4, 8'h80, -1, 1);
    repeat (12) tick();
    check_frame("rstmid new", 1, 4, 8'h80, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
